// File: rtl/vga_scan_controller.sv
// 640x480@60 VGA scan controller: timing counters, multiplier-free buffer addressing, RD_LAT-aligned outputs.
// Optional colour-bar test pattern enabled by defining VGA_SCAN_TEST_PATTERN_EN.
module vga_scan_controller #(
    parameter int RD_LAT      = 1,
    parameter int SCALE_SHIFT = 2,
    parameter int ADDR_W      = 15
) (
    input  logic              clk_25m,
    input  logic              rst,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic [7:0]        screen_data,
    output logic              valid,
    output logic              hsync,
    output logic              vsync,
    output logic              vblank,
    output logic              frame_start,
    input  logic              test_mode
);
    localparam logic [9:0] H_ACT    = 10'd640;
    localparam logic [9:0] H_SYNC_S = 10'd656;
    localparam logic [9:0] H_SYNC_E = 10'd752;
    localparam logic [9:0] H_LAST   = 10'd799;
    localparam logic [9:0] V_ACT    = 10'd480;
    localparam logic [9:0] V_SYNC_S = 10'd490;
    localparam logic [9:0] V_SYNC_E = 10'd492;
    localparam logic [9:0] V_LAST   = 10'd524;
    localparam logic [ADDR_W-1:0]      ROW_STRIDE = ADDR_W'(640 >> SCALE_SHIFT);
    localparam logic [SCALE_SHIFT-1:0] SUB_LAST   = '1;

    logic [9:0]        h_q, h_d, v_q, v_d;
    logic [ADDR_W-1:0] col_q, col_d, row_q, row_d, addr_hold_q;
    logic [RD_LAT-1:0] act_pipe_q, hs_pipe_q, vs_pipe_q;
    logic              h_wrap, act_raw, hs_raw, vs_raw;

    assign h_wrap  = (h_q == H_LAST);
    assign act_raw = (h_q < H_ACT) && (v_q < V_ACT);
    assign hs_raw  = !((h_q >= H_SYNC_S) && (h_q < H_SYNC_E));
    assign vs_raw  = !((v_q >= V_SYNC_S) && (v_q < V_SYNC_E));

    always_comb begin
        h_d   = h_wrap ? 10'd0 : h_q + 10'd1;
        v_d   = v_q;
        col_d = col_q;
        row_d = row_q;
        if (h_wrap) begin
            v_d   = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
            col_d = '0;
            if (v_q == V_LAST)
                row_d = '0;
            else if (v_q[SCALE_SHIFT-1:0] == SUB_LAST)
                row_d = row_q + ROW_STRIDE;
        end else if (act_raw && (h_q[SCALE_SHIFT-1:0] == SUB_LAST)) begin
            col_d = col_q + ADDR_W'(1);
        end
    end

    // Outside active video the address freezes so the buffer sees no toggling.
    assign rd_addr = act_raw ? (row_q + col_q) : addr_hold_q;

    always_ff @(posedge clk_25m) begin
        if (rst) begin
            h_q         <= '0;
            v_q         <= '0;
            col_q       <= '0;
            row_q       <= '0;
            addr_hold_q <= '0;
            act_pipe_q  <= '0;
            hs_pipe_q   <= '1;
            vs_pipe_q   <= '1;
        end else begin
            h_q         <= h_d;
            v_q         <= v_d;
            col_q       <= col_d;
            row_q       <= row_d;
            addr_hold_q <= rd_addr;
            act_pipe_q  <= (act_pipe_q << 1) | RD_LAT'(act_raw);
            hs_pipe_q   <= (hs_pipe_q << 1) | RD_LAT'(hs_raw);
            vs_pipe_q   <= (vs_pipe_q << 1) | RD_LAT'(vs_raw);
        end
    end

    assign valid       = act_pipe_q[RD_LAT-1];
    assign hsync       = hs_pipe_q[RD_LAT-1];
    assign vsync       = vs_pipe_q[RD_LAT-1];
    assign vblank      = (v_q >= V_ACT);
    assign frame_start = (h_q == 10'd0) && (v_q == V_ACT);

`ifdef VGA_SCAN_TEST_PATTERN_EN
    logic [9:0] h_pipe_q [RD_LAT];
    logic [7:0] bar_colour;

    always_ff @(posedge clk_25m) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) h_pipe_q[i] <= '0;
        end else begin
            h_pipe_q[0] <= h_q;
            for (int i = 1; i < RD_LAT; i++) h_pipe_q[i] <= h_pipe_q[i-1];
        end
    end

    // Bars are 80 pixels wide; the delayed column keeps them aligned with valid.
    always_comb begin
        bar_colour = 8'h00;
        if      (h_pipe_q[RD_LAT-1] < 10'd80)  bar_colour = 8'hFF;
        else if (h_pipe_q[RD_LAT-1] < 10'd160) bar_colour = 8'hFC;
        else if (h_pipe_q[RD_LAT-1] < 10'd240) bar_colour = 8'h1F;
        else if (h_pipe_q[RD_LAT-1] < 10'd320) bar_colour = 8'h1C;
        else if (h_pipe_q[RD_LAT-1] < 10'd400) bar_colour = 8'hE3;
        else if (h_pipe_q[RD_LAT-1] < 10'd480) bar_colour = 8'hE0;
        else if (h_pipe_q[RD_LAT-1] < 10'd560) bar_colour = 8'h03;
    end

    always_comb begin
        screen_data = 8'h00;
        if (valid) screen_data = test_mode ? bar_colour : rd_data;
    end
`else
    logic unused_test_mode;
    assign unused_test_mode = test_mode;

    always_comb begin
        screen_data = 8'h00;
        if (valid) screen_data = rd_data;
    end
`endif
endmodule
